// File: rtl/vocoder2_if.sv
// Sample-stream bundle for the two-band vocoder.
// Transfer rule: there is no valid/ready pair. The source presents a new
// data_in before every rising edge and the block consumes it at that edge;
// data_out and status are registered and change only on the rising edge.
interface vocoder2_if;
    logic [23:0] data_in;
    logic [23:0] data_out;
    logic        status;

    modport master (output data_in, input data_out, input status);
    modport slave  (input data_in, output data_out, output status);
endinterface

// File: rtl/vocoder2.sv
// Two-band channel vocoder: modulator envelopes scale a sawtooth carrier
// split into the same low/high bands. Five register stages from data_in
// to data_out: delay line, band split, envelope, mix, output.
module vocoder2 #(
    parameter logic [23:0] CARRIER_STEP = 24'h010000,
    parameter int          ENV_SHIFT    = 3
) (
    input logic       clk,
    input logic       rst,
    vocoder2_if.slave bus
);
    // Low band is the 4-tap moving average; arithmetic shift keeps it floored.
    function automatic logic signed [23:0] split_low(input logic signed [23:0] a,
                                                     input logic signed [23:0] b,
                                                     input logic signed [23:0] c,
                                                     input logic signed [23:0] d);
        logic signed [25:0] sum;
        logic signed [25:0] shr;
        sum = 26'(a) + 26'(b) + 26'(c) + 26'(d);
        shr = sum >>> 2;
        return shr[23:0];
    endfunction

    function automatic logic signed [23:0] sat_25(input logic signed [24:0] v);
        if (v[24] != v[23]) return v[24] ? 24'sh800000 : 24'sh7fffff;
        return v[23:0];
    endfunction

    // High band is the newest sample minus the low band, clamped to 24 bits.
    function automatic logic signed [23:0] split_high(input logic signed [23:0] x,
                                                      input logic signed [23:0] low);
        logic signed [24:0] diff;
        diff = 25'(x) - 25'(low);
        return sat_25(diff);
    endfunction

    // Magnitude with the single unrepresentable case clamped.
    function automatic logic [23:0] rectify(input logic signed [23:0] a);
        if (a == 24'sh800000) return 24'h7fffff;
        if (a[23]) return 24'(-a);
        return a;
    endfunction

    // One-pole follower; the signed difference lets the envelope fall as well as rise.
    function automatic logic [23:0] env_next(input logic [23:0] env, input logic [23:0] mag);
        logic signed [24:0] diff;
        logic signed [24:0] stp;
        logic signed [24:0] sum;
        diff = $signed({1'b0, mag}) - $signed({1'b0, env});
        stp  = diff >>> ENV_SHIFT;
        sum  = $signed({1'b0, env}) + stp;
        return sum[23:0];
    endfunction

    // Unsigned envelope times signed carrier band, rescaled by 2^23.
    function automatic logic signed [24:0] mix(input logic [23:0] env, input logic signed [23:0] c);
        logic signed [48:0] prod;
        prod = $signed({25'b0, env}) * 49'(c);
        return prod[47:23];
    endfunction

    logic signed [23:0] x0, x1, x2, x3;
    logic signed [23:0] cx0, cx1, cx2, cx3;
    logic [23:0]        phase;
    logic [23:0]        abs_low, abs_high;
    logic signed [23:0] c_low, c_high;
    logic signed [23:0] c_low_d, c_high_d;
    logic [23:0]        env_low, env_high;
    logic signed [24:0] p_low, p_high;
    logic [23:0]        data_out_q;
    logic [3:0]         cnt;

    logic signed [23:0] in_low_n, in_high_n, c_low_n, c_high_n;
    logic signed [25:0] out_sum;
    logic [23:0]        out_n;

    // Band split of both delay lines and saturating sum of the two mixed bands.
    always_comb begin
        in_low_n  = split_low(x0, x1, x2, x3);
        in_high_n = split_high(x0, in_low_n);
        c_low_n   = split_low(cx0, cx1, cx2, cx3);
        c_high_n  = split_high(cx0, c_low_n);
        out_sum   = 26'(p_low) + 26'(p_high);
        out_n     = out_sum[23:0];
        if (out_sum > 26'sd8388607)
            out_n = 24'h7fffff;
        else if (out_sum < -26'sd8388608)
            out_n = 24'h800000;
    end

    // Stage 1: modulator and carrier delay lines plus the phase accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0 <= '0; x1 <= '0; x2 <= '0; x3 <= '0;
            cx0 <= '0; cx1 <= '0; cx2 <= '0; cx3 <= '0;
            phase <= '0;
        end else begin
            x0 <= bus.data_in; x1 <= x0; x2 <= x1; x3 <= x2;
            cx0 <= phase; cx1 <= cx0; cx2 <= cx1; cx3 <= cx2;
            phase <= phase + CARRIER_STEP;
        end
    end

    // Stage 2: rectified modulator bands and raw carrier bands.
    always_ff @(posedge clk) begin
        if (rst) begin
            abs_low <= '0; abs_high <= '0;
            c_low <= '0; c_high <= '0;
        end else begin
            abs_low  <= rectify(in_low_n);
            abs_high <= rectify(in_high_n);
            c_low    <= c_low_n;
            c_high   <= c_high_n;
        end
    end

    // Stage 3: envelopes, with the carrier bands held one cycle to line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            env_low <= '0; env_high <= '0;
            c_low_d <= '0; c_high_d <= '0;
        end else begin
            env_low  <= env_next(env_low, abs_low);
            env_high <= env_next(env_high, abs_high);
            c_low_d  <= c_low;
            c_high_d <= c_high;
        end
    end

    // Stages 4 and 5: per-band products, then the saturated output sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_low <= '0; p_high <= '0;
            data_out_q <= '0;
        end else begin
            p_low      <= mix(env_low, c_low_d);
            p_high     <= mix(env_high, c_high_d);
            data_out_q <= out_n;
        end
    end

    // Edges since reset release, held at 15 so status never drops mid-stream.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt != 4'hf)
            cnt <= cnt + 4'd1;
    end

    assign bus.data_out = data_out_q;
    assign bus.status   = (cnt >= 4'd8);
endmodule

// File: tb/tb_vocoder2.sv
// Directed bench for vocoder2: a per-edge reference model of the pipeline
// supplies data_out expectations; hand-computed values cover reset, status,
// envelope start-up, rectifier clamp and carrier wrap.
module tb_vocoder2;
    localparam logic [23:0] STEP_MAIN = 24'h010000;
    localparam logic [23:0] STEP_W    = 24'h400000;
    localparam int          MAXE      = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vocoder2_if bus();
    vocoder2_if bus_w();

    vocoder2 #(.CARRIER_STEP(STEP_MAIN), .ENV_SHIFT(3)) dut   (.clk(clk), .rst(rst), .bus(bus));
    vocoder2 #(.CARRIER_STEP(STEP_W),    .ENV_SHIFT(3)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int e = 0;

    longint in_h[MAXE];
    longint abs_l[MAXE], abs_h[MAXE];
    longint cb_l[MAXE], cb_h[MAXE];
    longint env_l[MAXE], env_h[MAXE];
    longint p_l[MAXE], p_h[MAXE];
    longint out_m[MAXE];

    logic [23:0] ph_tab[6] = '{24'h400000, 24'h800000, 24'hC00000, 24'h000000, 24'h400000, 24'h800000};
    logic [23:0] ramp[9]   = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
        end
    endtask

    // Reference model helpers (integer arithmetic on sign-extended samples)
    function automatic longint sx24(input longint v);
        longint t;
        t = v & 16777215;
        return (t >= 8388608) ? t - 16777216 : t;
    endfunction

    function automatic longint sat24(input longint v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    function automatic longint mag24(input longint v);
        if (v == -8388608) return 8388607;
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint inp(input int k);
        if (k >= 1) return in_h[k];
        return 0;
    endfunction

    // Carrier sample entering the delay line at edge k: phase held before that edge.
    function automatic longint csamp(input int k);
        if (k >= 1) return sx24(longint'(STEP_MAIN) * longint'(k - 1));
        return 0;
    endfunction

    function automatic longint cbl_at(input int k);
        if (k >= 0) return cb_l[k];
        return 0;
    endfunction

    function automatic longint cbh_at(input int k);
        if (k >= 0) return cb_h[k];
        return 0;
    endfunction

    // Model state after edge j, built from the input history and earlier edges.
    task automatic model_edge(input int j);
        longint lo, hi, cl, ch;
        lo = (inp(j-1) + inp(j-2) + inp(j-3) + inp(j-4)) >>> 2;
        hi = sat24(inp(j-1) - lo);
        abs_l[j] = mag24(lo);
        abs_h[j] = mag24(hi);
        cl = (csamp(j-1) + csamp(j-2) + csamp(j-3) + csamp(j-4)) >>> 2;
        ch = sat24(csamp(j-1) - cl);
        cb_l[j] = cl;
        cb_h[j] = ch;
        env_l[j] = env_l[j-1] + ((abs_l[j-1] - env_l[j-1]) >>> 3);
        env_h[j] = env_h[j-1] + ((abs_h[j-1] - env_h[j-1]) >>> 3);
        p_l[j] = (env_l[j-1] * cbl_at(j-2)) >>> 23;
        p_h[j] = (env_h[j-1] * cbh_at(j-2)) >>> 23;
        out_m[j] = sat24(p_l[j-1] + p_h[j-1]);
    endtask

    // Driver: one edge with the given sample and reset level, then compare outputs.
    task automatic drive(input logic [23:0] d, input logic r);
        bus.data_in   = d;
        bus_w.data_in = d;
        rst           = r;
        @(posedge clk);
        #1;
        if (r) begin
            e = 0;
        end else if (e < MAXE - 1) begin
            e++;
            in_h[e] = sx24(longint'(d));
            model_edge(e);
        end
        check_eq("data_out", {8'h0, bus.data_out}, 32'(out_m[e] & 16777215));
        check_eq("status", {31'h0, bus.status}, {31'h0, (e >= 8)});
    endtask

    initial begin
        for (int i = 0; i < MAXE; i++) begin
            in_h[i] = 0; abs_l[i] = 0; abs_h[i] = 0; cb_l[i] = 0; cb_h[i] = 0;
            env_l[i] = 0; env_h[i] = 0; p_l[i] = 0; p_h[i] = 0; out_m[i] = 0;
        end
        bus.data_in   = 24'h123456;
        bus_w.data_in = 24'h123456;

        // Reset held three edges with a nonzero input
        for (int i = 0; i < 3; i++) begin
            drive(24'h123456, 1'b1);
            check_eq("rst_out", {8'h0, bus.data_out}, 32'h0);
            check_eq("rst_status", {31'h0, bus.status}, 32'h0);
        end

        // Zero input: output stays 0, status rises after edge 8
        for (int i = 1; i <= 50; i++) begin
            drive(24'h000000, 1'b0);
            check_eq("zero_out", {8'h0, bus.data_out}, 32'h0);
            if (i == 1) check_eq("phase_e1", {8'h0, dut.phase}, 32'h010000);
            if (i == 7) check_eq("status_e7", {31'h0, bus.status}, 32'h0);
            if (i == 8) check_eq("status_e8", {31'h0, bus.status}, 32'h1);
        end

        // Step input
        drive(24'h000000, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            drive(24'h100000, 1'b0);
            if (i == 3) check_eq("env_low_e3", {8'h0, dut.env_low}, 32'h008000);
            if (i == 4) check_eq("env_low_e4", {8'h0, dut.env_low}, 32'h017000);
            if (i == 8) check_eq("abs_low_full", {8'h0, dut.abs_low}, 32'h100000);
            if (i == 8) check_eq("abs_high_full", {8'h0, dut.abs_high}, 32'h0);
            if (i == 60) begin
                check_eq("env_low_model", {8'h0, dut.env_low}, 32'(env_l[e] & 16777215));
                check_eq("env_high_model", {8'h0, dut.env_high}, 32'(env_h[e] & 16777215));
            end
        end

        // Mid-stream reset while the output is live
        drive(24'h100000, 1'b1);
        check_eq("midrst_out", {8'h0, bus.data_out}, 32'h0);
        check_eq("midrst_status", {31'h0, bus.status}, 32'h0);

        // Full-scale negative input
        for (int i = 1; i <= 40; i++) begin
            drive(24'h800000, 1'b0);
            if (i == 5) check_eq("abs_clamp", {8'h0, dut.abs_low}, 32'h7FFFFF);
            if (i == 40) check_eq("env_neg_model", {8'h0, dut.env_low}, 32'(env_l[e] & 16777215));
        end

        // Carrier wrap on the fast-carrier instance
        drive(24'h000000, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            drive(24'h000000, 1'b0);
            check_eq("wrap_phase", {8'h0, dut_w.phase}, {8'h0, ph_tab[i-1]});
            if (i == 5) check_eq("wrap_c_low", {8'h0, dut_w.c_low}, 32'h00E00000);
        end

        // Small ramp with a reset asserted part way through
        drive(24'h000000, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i == 5) begin
                drive(ramp[i], 1'b1);
                check_eq("ramp_rst_out", {8'h0, bus.data_out}, 32'h0);
                check_eq("ramp_rst_status", {31'h0, bus.status}, 32'h0);
            end
            drive(ramp[i], 1'b0);
            check_eq("ramp_bound", {31'h0, ($signed(bus.data_out) <= 24'sd8) && ($signed(bus.data_out) >= -24'sd8)}, 32'h1);
        end
        for (int i = 0; i < 8; i++) begin
            drive(24'h000000, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
